shock_event_detector: RTL

Front end of the shock path: samples the raw vibration/shock sensor GPIO, synchronizes and debounces it, and emits one clean single-cycle `o_shock` pulse per physical shock. That pulse feeds the downstream shock-duration timer's `i_shock` input. A cooldown window and a re-arm rule prevent one impact from producing a burst of triggers. An optional event counter feeds the score/display logic.

---
 rtl/shock_pkg.sv | 24 ++
 rtl/sensor_sync.sv | 20 ++
 rtl/shock_event_detector.sv | 115 +++++++++++
 3 files changed

// File: rtl/shock_pkg.sv
// Shared shock-path FSM states and default timing constants.
// Also used by the downstream shock-duration timer.
package shock_pkg;

  localparam int unsigned SHOCK_SYNC_STAGES     = 2;
  localparam int unsigned SHOCK_DEBOUNCE_CYCLES = 50_000;
  localparam int unsigned SHOCK_COOLDOWN_CYCLES = 25_000_000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_FIRE,
    S_COOLDOWN,
    S_REARM
  } shock_det_state_e;

  // Width of a timer shared by two timed states, never below one bit.
  function automatic int unsigned shock_cnt_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sensor_sync.sv
// N-stage reset-to-0 synchronizer for a single asynchronous input bit.
module sensor_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_r;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_r <= '0;
    else          sync_r <= {sync_r[STAGES-2:0], i_d};
  end

  assign o_q = sync_r[STAGES-1];

endmodule

// File: rtl/shock_event_detector.sv
// Synchronize, debounce and rate-limit the shock sensor into one o_shock pulse per impact.
// Optional saturating event counter enabled by the SHOCK_DET_COUNT_EN macro.
module shock_event_detector
  import shock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SHOCK_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = SHOCK_DEBOUNCE_CYCLES,
  parameter int unsigned COOLDOWN_CYCLES = SHOCK_COOLDOWN_CYCLES,
  parameter int unsigned COUNT_W         = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sensor,
  input  logic               i_enable,
  input  logic               i_clear_count,
  output logic               o_shock,
  output logic               o_busy,
  output logic [COUNT_W-1:0] o_shock_count
);

  localparam int unsigned CNT_W = shock_cnt_w(DEBOUNCE_CYCLES, COOLDOWN_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

  shock_det_state_e state_r, state_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             sens_s;
  logic             fire_entry_c;

  sensor_sync #(.STAGES(SYNC_STAGES)) u_sensor_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_sensor),
    .o_q     (sens_s)
  );

  // Next-state and shared timer update.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    case (state_r)
      S_IDLE: begin
        cnt_nxt = '0;
        if (i_enable && sens_s) state_nxt = S_DEBOUNCE;
      end
      S_DEBOUNCE: begin
        if (!sens_s || !i_enable) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (cnt_r == DEB_LAST) begin
          state_nxt = S_FIRE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_r + CNT_W'(1);
        end
      end
      S_FIRE: begin
        state_nxt = S_COOLDOWN;
        cnt_nxt   = '0;
      end
      S_COOLDOWN: begin
        if (cnt_r == COOL_LAST) begin
          state_nxt = S_REARM;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_r + CNT_W'(1);
        end
      end
      S_REARM: begin
        if (!sens_s) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign fire_entry_c = (state_nxt == S_FIRE);

  // Outputs are registered from the next state so they track state_r exactly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      o_shock <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      o_shock <= fire_entry_c;
      o_busy  <= (state_nxt == S_COOLDOWN) || (state_nxt == S_REARM);
    end
  end

`ifdef SHOCK_DET_COUNT_EN
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // A clear that coincides with a new shock keeps that shock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_shock_count <= '0;
    end else if (i_clear_count) begin
      o_shock_count <= fire_entry_c ? COUNT_W'(1) : '0;
    end else if (fire_entry_c && (o_shock_count != COUNT_MAX)) begin
      o_shock_count <= o_shock_count + COUNT_W'(1);
    end
  end
`else
  logic unused_clear_count;
  assign unused_clear_count = i_clear_count;
  assign o_shock_count      = '0;
`endif

endmodule
